// File: rtl/mem_bus_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_bus_responder: byte-wide bus target with on-chip RAM and an I/O      |
// | window (TX FIFO, RX holding register, status). Optional build macro:     |
// | MEM_BUS_RESPONDER_HALT_EN enables the sticky halt flag.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_bus_responder #(
  parameter int ADDR_WIDTH    = 17,
  parameter int TX_DEPTH_LOG2 = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] bus_a,
  input  logic        bus_wr,
  input  logic [7:0]  bus_w_data,
  output logic [7:0]  bus_r_data,
  output logic        rdy_out,
  output logic        io_tx_valid,
  output logic [7:0]  io_tx_data,
  input  logic        io_tx_ready,
  input  logic        io_rx_valid,
  input  logic [7:0]  io_rx_data,
  output logic        io_rx_ready,
  output logic        halt_out
);

  localparam int          c_RAM_BYTES = 1 << ADDR_WIDTH;
  localparam int          c_TX_DEPTH  = 1 << TX_DEPTH_LOG2;
  localparam int          c_CNT_W     = TX_DEPTH_LOG2 + 1;
  localparam logic [17:0] c_IO_DATA   = 18'h30000;
  localparam logic [17:0] c_IO_CTRL   = 18'h30004;

  logic [7:0]               r_mem    [c_RAM_BYTES];
  logic [7:0]               r_tx_buf [c_TX_DEPTH];
  logic [TX_DEPTH_LOG2-1:0] r_tx_wr_ptr;
  logic [TX_DEPTH_LOG2-1:0] r_tx_rd_ptr;
  logic [c_CNT_W-1:0]       r_tx_count;
  logic                     r_rx_full;
  logic [7:0]               r_rx_data;
  logic [7:0]               r_bus_r_data;

  logic [17:0]           w_addr;
  logic [ADDR_WIDTH-1:0] w_ram_idx;
  logic                  w_ram_sel;
  logic                  w_data_sel;
  logic                  w_ctrl_sel;
  logic                  w_tx_full;
  logic                  w_accept;
  logic                  w_ram_wr;
  logic                  w_tx_push;
  logic                  w_tx_pop;
  logic                  w_rx_load;
  logic                  w_rx_pop;
  logic [7:0]            w_rd_byte;
  logic                  w_unused_addr;

  assign w_addr        = bus_a[17:0];
  assign w_ram_idx     = bus_a[ADDR_WIDTH-1:0];
  assign w_unused_addr = ^bus_a[31:18];
  assign w_ram_sel     = ~w_addr[17];
  assign w_data_sel    = (w_addr == c_IO_DATA);
  assign w_ctrl_sel    = (w_addr == c_IO_CTRL);

  // The stall is purely a function of FIFO occupancy; a full FIFO freezes the bus.
  assign w_tx_full = (r_tx_count == c_CNT_W'(c_TX_DEPTH));
  assign w_accept  = ~w_tx_full;
  assign rdy_out   = w_accept;

  assign w_ram_wr  = w_accept & bus_wr & w_ram_sel;
  assign w_tx_push = w_accept & bus_wr & w_data_sel;
  assign w_tx_pop  = io_tx_valid & io_tx_ready;
  assign w_rx_load = io_rx_valid & ~r_rx_full;
  assign w_rx_pop  = w_accept & ~bus_wr & w_data_sel;

  assign io_tx_valid = (r_tx_count != '0);
  assign io_tx_data  = r_tx_buf[r_tx_rd_ptr];
  assign io_rx_ready = ~r_rx_full;
  assign bus_r_data  = r_bus_r_data;

  always_comb begin
    w_rd_byte = 8'h00;
    if (w_ram_sel) begin
      w_rd_byte = r_mem[w_ram_idx];
    end else if (w_data_sel) begin
      w_rd_byte = r_rx_full ? r_rx_data : 8'h00;
    end else if (w_ctrl_sel) begin
      w_rd_byte = {6'b0, r_rx_full, w_tx_full};
    end
  end

  // Storage arrays carry no reset so RAM contents survive a reset.
  always_ff @(posedge clk_in) begin
    if (w_ram_wr) begin
      r_mem[w_ram_idx] <= bus_w_data;
    end
    if (w_tx_push) begin
      r_tx_buf[r_tx_wr_ptr] <= bus_w_data;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_bus_r_data <= 8'h00;
    end else if (w_accept && !bus_wr) begin
      r_bus_r_data <= w_rd_byte;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_tx_wr_ptr <= '0;
      r_tx_rd_ptr <= '0;
      r_tx_count  <= '0;
    end else begin
      if (w_tx_push) begin
        r_tx_wr_ptr <= r_tx_wr_ptr + 1'b1;
      end
      if (w_tx_pop) begin
        r_tx_rd_ptr <= r_tx_rd_ptr + 1'b1;
      end
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_count <= r_tx_count + c_CNT_W'(1);
        2'b01:   r_tx_count <= r_tx_count - c_CNT_W'(1);
        default: r_tx_count <= r_tx_count;
      endcase
    end
  end

  // A load only happens while empty, so it can never collide with a real pop.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_rx_full <= 1'b0;
      r_rx_data <= 8'h00;
    end else if (w_rx_load) begin
      r_rx_full <= 1'b1;
      r_rx_data <= io_rx_data;
    end else if (w_rx_pop) begin
      r_rx_full <= 1'b0;
    end
  end

`ifdef MEM_BUS_RESPONDER_HALT_EN
  logic r_halt;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_halt <= 1'b0;
    end else if (w_accept && bus_wr && w_ctrl_sel) begin
      r_halt <= 1'b1;
    end
  end

  assign halt_out = r_halt;
`else
  assign halt_out = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_bus_responder: scoreboard bench for mem_bus_responder.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_bus_responder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [31:0] bus_a = '0;
  logic        bus_wr = 1'b0;
  logic [7:0]  bus_w_data = '0;
  logic [7:0]  bus_r_data;
  logic        rdy_out;
  logic        io_tx_valid;
  logic [7:0]  io_tx_data;
  logic        io_tx_ready = 1'b0;
  logic        io_rx_valid = 1'b0;
  logic [7:0]  io_rx_data = '0;
  logic        io_rx_ready;
  logic        halt_out;

  int         n_checks = 0;
  int         n_fail = 0;
  int         n_tx_seen = 0;
  logic [7:0] q_rd [$];
  logic [7:0] q_tx [$];

`ifdef MEM_BUS_RESPONDER_HALT_EN
  localparam logic c_HALT_EXP = 1'b1;
`else
  localparam logic c_HALT_EXP = 1'b0;
`endif

  mem_bus_responder dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .bus_a      (bus_a),
    .bus_wr     (bus_wr),
    .bus_w_data (bus_w_data),
    .bus_r_data (bus_r_data),
    .rdy_out    (rdy_out),
    .io_tx_valid(io_tx_valid),
    .io_tx_data (io_tx_data),
    .io_tx_ready(io_tx_ready),
    .io_rx_valid(io_rx_valid),
    .io_rx_data (io_rx_data),
    .io_rx_ready(io_rx_ready),
    .halt_out   (halt_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Behaves like the paused CPU: holds the write until an edge with rdy_out high.
  task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
    logic was_rdy;
    bit   done;
    done = 1'b0;
    bus_a = a; bus_wr = 1'b1; bus_w_data = d;
    for (int i = 0; i < 60 && !done; i++) begin
      was_rdy = rdy_out;
      tick();
      if (was_rdy) begin
        done = 1'b1;
        if (a[17:0] == 18'h30000) q_tx.push_back(d);
      end
    end
    if (!done) check("write_accept", {31'b0, done}, 32'd1);
    bus_wr = 1'b0; bus_a = '0;
  endtask

  task automatic bus_read(input string tag, input logic [31:0] a, input logic [7:0] exp);
    q_rd.push_back(exp);
    bus_a = a; bus_wr = 1'b0;
    tick();
    check(tag, bus_r_data, q_rd.pop_front());
    bus_a = '0;
  endtask

  task automatic drain_tx();
    io_tx_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!io_tx_valid) break;
      tick();
    end
    io_tx_ready = 1'b0;
    check("tx_drained", io_tx_valid, 1'b0);
    check("tx_sb_empty", q_tx.size(), 0);
  endtask

  // Consumer side: a byte leaves the FIFO at the edge following a valid&ready half-cycle.
  always @(negedge clk_in) begin
    if (rst_in && io_tx_valid && io_tx_ready) begin
      check("tx_sb_nonempty", {31'b0, q_tx.size() != 0}, 32'd1);
      if (q_tx.size() != 0) check("tx_order", io_tx_data, q_tx.pop_front());
      n_tx_seen++;
    end
  end

  initial begin
    logic [31:0] addrs [4];
    logic [7:0]  datas [4];
    addrs = '{32'h0_0000, 32'h1_FFFF, 32'h0_ABCD, 32'h0_0011};
    datas = '{8'h3C, 8'h5A, 8'hFF, 8'h00};

    #12;
    check("rst_r_data", bus_r_data, 8'h00);
    check("rst_rdy", rdy_out, 1'b1);
    check("rst_tx_valid", io_tx_valid, 1'b0);
    check("rst_rx_ready", io_rx_ready, 1'b1);
    check("rst_halt", halt_out, 1'b0);
    tick();
    rst_in = 1'b1;
    tick();

    bus_write(32'h10, 8'hA5);
    bus_read("ram_roundtrip", 32'h10, 8'hA5);
    foreach (addrs[i]) bus_write(addrs[i], datas[i]);
    foreach (addrs[i]) bus_read("ram_pattern", addrs[i], datas[i]);
    bus_read("ram_high_bits_ignored", 32'h1234_0010, 8'hA5);

    bus_write(32'h3_0008, 8'h77);
    bus_read("io_other", 32'h3_0008, 8'h00);
    bus_read("status_idle", 32'h3_0004, 8'h00);

    io_tx_ready = 1'b0;
    for (int i = 1; i <= 8; i++) bus_write(32'h3_0000, 8'(i));
    check("rdy_full", rdy_out, 1'b0);
    check("tx_head", io_tx_data, 8'h01);
    fork
      bus_write(32'h3_0000, 8'h09);
      begin
        tick();
        tick();
        check("stall_hold", rdy_out, 1'b0);
        io_tx_ready = 1'b1;
        tick();
        io_tx_ready = 1'b0;
        check("rdy_rise", rdy_out, 1'b1);
      end
    join
    check("refull", rdy_out, 1'b0);
    drain_tx();
    check("tx_count_9", n_tx_seen, 9);

    for (int i = 0; i < 3; i++) bus_write(32'h3_0000, 8'(8'h21 + i));
    io_tx_ready = 1'b1;
    for (int i = 3; i < 9; i++) bus_write(32'h3_0000, 8'(8'h21 + i));
    io_tx_ready = 1'b0;
    check("pushpop_rdy", rdy_out, 1'b1);
    bus_read("pushpop_status", 32'h3_0004, 8'h00);
    for (int i = 9; i < 13; i++) bus_write(32'h3_0000, 8'(8'h21 + i));
    check("count7_rdy", rdy_out, 1'b1);
    bus_write(32'h3_0000, 8'h2E);
    check("count8_stall", rdy_out, 1'b0);
    drain_tx();
    check("tx_count_23", n_tx_seen, 23);

    io_rx_data = 8'h5C; io_rx_valid = 1'b1;
    tick();
    io_rx_valid = 1'b0;
    check("rx_ready_low", io_rx_ready, 1'b0);
    io_rx_data = 8'h99; io_rx_valid = 1'b1;
    tick();
    io_rx_valid = 1'b0;
    bus_read("rx_status", 32'h3_0004, 8'h02);
    bus_read("rx_data", 32'h3_0000, 8'h5C);
    check("rx_ready_high", io_rx_ready, 1'b1);
    bus_read("rx_empty_read", 32'h3_0000, 8'h00);

    bus_write(32'h3_0004, 8'h00);
    check("halt_set", halt_out, c_HALT_EXP);
    tick();
    tick();
    check("halt_sticky", halt_out, c_HALT_EXP);

    for (int i = 0; i < 4; i++) bus_write(32'h3_0000, 8'(8'hB0 + i));
    io_rx_data = 8'h42; io_rx_valid = 1'b1;
    tick();
    io_rx_valid = 1'b0;
    check("pre_reset_tx_valid", io_tx_valid, 1'b1);
    @(posedge clk_in);
    #3 rst_in = 1'b0;
    #1;
    check("mid_rst_tx_valid", io_tx_valid, 1'b0);
    check("mid_rst_halt", halt_out, 1'b0);
    check("mid_rst_rdy", rdy_out, 1'b1);
    check("mid_rst_rx_ready", io_rx_ready, 1'b1);
    check("mid_rst_r_data", bus_r_data, 8'h00);
    q_tx.delete();
    tick();
    rst_in = 1'b1;
    tick();
    bus_read("ram_after_reset", 32'h10, 8'hA5);
    bus_read("rx_after_reset", 32'h3_0000, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_bus_responder.md
# mem_bus_responder

- Target side of the CPU's byte-wide memory bus (`mem_a`, `mem_dout`, `mem_wr`, `mem_din`, `rdy_in`).
- Sits outside the `cpu` top and answers every bus cycle from one of two places:
  - an on-chip byte RAM;
  - a small I/O window holding a TX byte FIFO, an RX holding register and a status byte.
- Drives the CPU's ready input low to stall the core while the TX FIFO is full.

## Interface
Parameters:
- `ADDR_WIDTH`, 17: RAM address bits; RAM holds 2^ADDR_WIDTH bytes, indexed by `bus_a[ADDR_WIDTH-1:0]`.
- `TX_DEPTH_LOG2`, 3: log2 of TX FIFO depth (8 entries).

Ports:
- `clk_in`  input  1  system clock; all state updates on the rising edge.
- `rst_in`  input  1  reset, asynchronous assert, active-low.
- `bus_a`  input  32  byte address from the CPU `mem_a`; only bits 17:0 are decoded.
- `bus_wr`  input  1  1 = write, 0 = read; from the CPU `mem_wr`.
- `bus_w_data`  input  8  write byte, from the CPU `mem_dout`.
- `bus_r_data`  output  8  read byte, to the CPU `mem_din`; registered.
- `rdy_out`  output  1  to the CPU `rdy_in`; low pauses the CPU.
- `io_tx_valid`  output  1  TX FIFO head is valid.
- `io_tx_data`  output  8  TX FIFO head byte.
- `io_tx_ready`  input  1  consumer accepts the head byte.
- `io_rx_valid`  input  1  producer offers a byte.
- `io_rx_data`  input  8  offered byte.
- `io_rx_ready`  output  1  RX register is empty (equals ~rx_full).
- `halt_out`  output  1  sticky halt flag; see Configuration.

## Operation
Address decode on `bus_a[17:0]`:
- Bit 17 = 0: RAM region.
- Bit 17 = 1: I/O region.
  - 0x30000: DATA register.
  - 0x30004: STATUS/CTRL register.
  - Any other I/O address: reads return 0x00; writes are ignored.

Bus cycles:
- A bus cycle is accepted every clock edge with `rdy_out`=1.
- RAM write: mem[addr] <= `bus_w_data`.
- RAM read: `bus_r_data` <= mem[addr].
- RAM contents are not cleared by reset.
- DATA write: push `bus_w_data` into the TX FIFO. Accepted only when the FIFO is not full.
- DATA read: `bus_r_data` <= RX byte if rx_full, else 0x00. Clears rx_full (pop).
  - Any read cycle addressing 0x30000 pops, including speculative fetches.
- STATUS read: `bus_r_data` <= {6'b0, rx_full, tx_full}.
- CTRL write (0x30004): see Configuration.

TX FIFO:
- Circular buffer of 2^TX_DEPTH_LOG2 bytes.
- Write pointer, read pointer and a count of width TX_DEPTH_LOG2+1. Pointers wrap modulo depth.
- `io_tx_valid` = (count != 0). `io_tx_data` = buf[rd_ptr].
- Pop on `io_tx_valid` & `io_tx_ready`.
- Push and pop in the same cycle: both pointers advance and count is unchanged. When the FIFO was empty, the pushed byte appears at the head the next cycle.

Stall:
- `rdy_out` = ~tx_full. Combinational from the count register.
- While `rdy_out`=0 no bus cycle is accepted: no RAM write, no pop, `bus_r_data` holds.
- A write to DATA while full is therefore dropped. The paused CPU re-presents it once `rdy_out` rises.
- A consumer pop in a full cycle raises `rdy_out` the next cycle.

RX register:
- Loads `io_rx_data` and sets rx_full on `io_rx_valid` & `io_rx_ready`.
- A pop and an arrival cannot coincide, because ready is low while full. A new byte is taken no earlier than the cycle after the pop.

## Timing
Reset (`rst_in`=0, asynchronous):
- `bus_r_data`=0x00, count=0, pointers=0, rx_full=0, `halt_out`=0.
- Hence `rdy_out`=1, `io_tx_valid`=0, `io_rx_ready`=1.
- Reset asserted mid-operation discards FIFO contents and any pending RX byte immediately.

Latency:
- Read data: address presented at edge N is visible on `bus_r_data` after edge N+1. This is one-cycle latency, matching the CPU controller's byte sequencing.
- Writes take effect at the accepting edge.
- A read of the same RAM address in the following cycle returns the new byte.
- A same-cycle read and write cannot occur, since the bus is single-ported.
- TX byte written at edge N: `io_tx_valid` high after edge N.
- RX byte accepted at edge N: STATUS shows rx_full for a read presented at edge N+1.

## Configuration
- Macro: `MEM_BUS_RESPONDER_HALT_EN`.
- Defined: a write of any value to 0x30004 sets `halt_out`=1. It stays set until reset. This is used by simulation benches to end a run.
- Undefined: writes to 0x30004 are ignored and `halt_out` is tied 0. The port is present in both builds.

## Test plan
- RAM round trip: write 0xA5 to 0x00010, read 0x00010 on the next cycle -> `bus_r_data`=0xA5 one cycle after the read address; reset leaves RAM data intact.
- TX fill/stall: `io_tx_ready`=0, write bytes 0x01..0x08 to 0x30000 -> `rdy_out` falls after the 8th; 9th write 0x09 held. Raise `io_tx_ready` for one cycle -> `io_tx_data` sequence starts with 0x01, `rdy_out`=1, 0x09 accepted, final order 0x01..0x09.
- Simultaneous push/pop at count=3 -> count stays 3, wrap past index 7 preserves order.
- RX: offer 0x5C -> `io_rx_ready` drops; STATUS read = 0x02; DATA read = 0x5C; second DATA read = 0x00; `io_rx_ready` high again.
- Halt: with macro, write 0x00 to 0x30004 -> `halt_out`=1 next cycle and sticky; without macro it stays 0. Assert `rst_in` low mid-burst with 4 bytes queued -> `io_tx_valid`=0, `halt_out`=0 immediately.
